// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and frame field layout.
// Field offsets are functions of the field width W so every stage slices frames identically.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  function automatic int frame_w(input int w);
    return 4 * w;
  endfunction

  function automatic int op_code_lo(input int w);
    return 3 * w;
  endfunction

  function automatic int reg_r_lo(input int w);
    return 2 * w;
  endfunction

  function automatic int reg_w_lo(input int w);
    return w;
  endfunction

  localparam int DATA_LO = 0;

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x DW words, one synchronous write port and one
// synchronous read port with read-enable. Contents survive reset.
module prog_ram #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register; the program must outlive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fetch_mem.sv
// Instruction fetch: program RAM, fetch pointer and valid/ready frame output.
// Define FETCH_WRAP_EN to wrap from the last word back to 0 instead of halting.
module fetch_mem
  import cpu_pkg::*;
#(
  parameter int W  = 4,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ld_we,
  input  logic [AW-1:0]       ld_addr,
  input  logic [4*W-1:0]      ld_data,
  input  logic                jmp,
  input  logic [AW-1:0]       jmp_addr,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [AW-1:0]       pc,
  output logic [4*W-1:0]      data_frame,
  output logic [W-1:0]        op_code,
  output logic [W-1:0]        reg_r,
  output logic [W-1:0]        reg_w,
  output logic [W-1:0]        data,
  output logic                halted
);

  localparam int FW = frame_w(W);

  fetch_state_t  state, state_nx;
  logic [AW-1:0] fpc, fpc_nx, pc_nx, pc_inc, rd_addr;
  logic [FW-1:0] ram_q;
  logic          accept, at_end, issue_ok, frame_live;

  assign out_valid = (state == ST_VALID);
  assign accept    = out_valid & out_ready;
  assign pc_inc    = pc + AW'(1'b1);

`ifdef FETCH_WRAP_EN
  assign at_end = 1'b0;
  assign halted = 1'b0;
`else
  assign at_end = (pc == {AW{1'b1}});
  assign halted = (state == ST_HALT);
`endif

  // After an accept the next word is pc+1, which fpc only holds from the next edge.
  assign rd_addr  = (state == ST_VALID) ? pc_inc : fpc;
  assign issue_ok = en & ~ld_we & ~jmp &
                    ((state == ST_IDLE) | (accept & ~at_end));

  // The sync read lands on the issuing edge, so the in-flight (WAIT) phase
  // never outlasts that edge and the register goes straight to VALID.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nx = state;
    fpc_nx   = fpc;
    pc_nx    = pc;
    if (jmp) begin
      state_nx = ST_IDLE;
      fpc_nx   = jmp_addr;
    end else begin
      unique case (state)
        ST_IDLE: if (issue_ok) begin
          state_nx = ST_VALID;
          pc_nx    = rd_addr;
        end
        ST_VALID: if (accept) begin
          fpc_nx = pc_inc;
          if (at_end)        state_nx = ST_HALT;
          else if (issue_ok) pc_nx    = rd_addr;
          else               state_nx = ST_IDLE;
        end
        ST_HALT: ;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fpc        <= '0;
      pc         <= '0;
      frame_live <= 1'b0;
    end else begin
      state <= state_nx;
      fpc   <= fpc_nx;
      pc    <= pc_nx;
      if (issue_ok) frame_live <= 1'b1;
    end
  end

  prog_ram #(.DW(FW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (issue_ok),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // The RAM read register has no reset, so the frame is gated to zero until a read lands.
  assign data_frame = frame_live ? ram_q : '0;
  assign op_code    = data_frame[op_code_lo(W) +: W];
  assign reg_r      = data_frame[reg_r_lo(W)   +: W];
  assign reg_w      = data_frame[reg_w_lo(W)   +: W];
  assign data       = data_frame[DATA_LO       +: W];

endmodule

// File: tb/tb_fetch_mem.sv
// Directed bench for fetch_mem (W=4, AW=4): load, stream, backpressure,
// jump flush, load-during-fetch, end of program and async reset.
module tb_fetch_mem;

  logic        clk = 1'b0;
  logic        rst, en, ld_we, jmp, out_ready;
  logic [3:0]  ld_addr, jmp_addr;
  logic [15:0] ld_data;
  logic        out_valid, halted;
  logic [3:0]  pc, op_code, reg_r, reg_w, data;
  logic [15:0] data_frame;

  logic [15:0] model [16];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_mem #(.W(4), .AW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .jmp(jmp), .jmp_addr(jmp_addr), .out_ready(out_ready),
    .out_valid(out_valid), .pc(pc), .data_frame(data_frame), .op_code(op_code),
    .reg_r(reg_r), .reg_w(reg_w), .data(data), .halted(halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] exp_pc);
    logic [15:0] w;
    w = model[exp_pc];
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"},    32'(pc),        32'(exp_pc));
    check({tag, "_frame"}, 32'(data_frame), 32'(w));
    check({tag, "_op"},    32'(op_code),   32'(w[15:12]));
    check({tag, "_data"},  32'(data),      32'(w[3:0]));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld_we = 1'b0; jmp = 1'b0; out_ready = 1'b0;
    ld_addr = '0; jmp_addr = '0; ld_data = '0;
    for (int i = 0; i < 16; i++)
      model[i] = {4'(i), 4'(15 - i), 4'(i + 3), 4'(i * 5)};
    model[0] = 16'h1234;
    model[1] = 16'hA5F0;

    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc",    32'(pc),        32'd0);
    check("rst_frame", 32'(data_frame), 32'd0);
    check("rst_halt",  32'(halted),    32'd0);
    check("rst_op",    32'(op_code),   32'd0);
    step(); step();
    rst = 1'b0;

    // Program load
    for (int i = 0; i < 16; i++) begin
      ld_we = 1'b1; ld_addr = 4'(i); ld_data = model[i];
      step();
      check("load_idle_valid", 32'(out_valid), 32'd0);
    end
    ld_we = 1'b0;

    // Stream first two words
    en = 1'b1; out_ready = 1'b1;
    step();
    check_frame("f0", 4'd0);
    check("f0_regr", 32'(reg_r), 32'h2);
    check("f0_regw", 32'(reg_w), 32'h3);
    step();
    check_frame("f1", 4'd1);
    step();
    check_frame("f2", 4'd2);

    // Backpressure on pc=2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_frame("bp_hold", 4'd2);
    end
    out_ready = 1'b1;
    step();
    check_frame("bp_f3", 4'd3);
    step();
    check_frame("f4", 4'd4);

    // Jump flush while pc=4 is held
    out_ready = 1'b0; jmp = 1'b1; jmp_addr = 4'd9;
    step();
    check("jmp_bubble", 32'(out_valid), 32'd0);
    jmp = 1'b0;
    step();
    check_frame("jmp_f9", 4'd9);
    out_ready = 1'b1;
    step();
    check_frame("f10", 4'd10);

    // Load during fetch: frame 10 held, words 11/12 rewritten
    out_ready = 1'b0; ld_we = 1'b1; ld_addr = 4'd11; ld_data = 16'hBEEF;
    step();
    model[11] = 16'hBEEF;
    check_frame("ld_hold0", 4'd10);
    ld_addr = 4'd12; ld_data = 16'hCAFE;
    out_ready = 1'b1;
    step();
    model[12] = 16'hCAFE;
    check("ld_no_issue", 32'(out_valid), 32'd0);
    ld_we = 1'b0;
    step();
    check_frame("ld_f11", 4'd11);
    step();
    check_frame("ld_f12", 4'd12);
    step(); check_frame("f13", 4'd13);
    step(); check_frame("f14", 4'd14);
    step(); check_frame("f15", 4'd15);

    // End of program
    step();
`ifdef FETCH_WRAP_EN
    check_frame("wrap_f0", 4'd0);
    check("wrap_halt", 32'(halted), 32'd0);
`else
    check("end_halt",  32'(halted),    32'd1);
    check("end_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_stay", 32'(halted),    32'd1);
      check("halt_nov",  32'(out_valid), 32'd0);
    end
    jmp = 1'b1; jmp_addr = 4'd0;
    step();
    check("unhalt", 32'(halted), 32'd0);
    jmp = 1'b0;
    step();
    check_frame("resume_f0", 4'd0);
`endif

    // Stream to pc=6, then async reset between edges
    for (int i = 1; i <= 6; i++) begin
      step();
      check_frame("pre_rst", 4'(i));
    end
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc",    32'(pc),        32'd0);
    check("arst_frame", 32'(data_frame), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_frame("post_rst_f0", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_mem.md
Name: fetch_mem

Overview:
- Parametrised successor to the instruction memory.
- Holds the program in a sync-read RAM with a load port for programming.
- Owns the program counter and presents one decoded instruction frame per cycle to the decoder over a valid/ready handshake.
- Supports jumps, stalls and end-of-program halt. Sits between the program loader and the decode stage.

Parameters:
- W, 4, field width in bits. Frame is 4*W bits: op_code, reg_r, reg_w, data.
- AW, 4, address width.
- DEPTH, 2**AW, number of words. Derived; not overridden independently.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable.
- ld_we  in  1  program-load write strobe.
- ld_addr  in  AW  load address.
- ld_data  in  4*W  load word.
- jmp  in  1  redirect request.
- jmp_addr  in  AW  redirect target.
- out_ready  in  1  decoder accepts the frame.
- out_valid  out  1  frame valid.
- pc  out  AW  address of the presented frame.
- data_frame  out  4*W  raw word.
- op_code  out  W  data_frame[4W-1:3W].
- reg_r  out  W  data_frame[3W-1:2W].
- reg_w  out  W  data_frame[2W-1:W].
- data  out  W  data_frame[W-1:0].
- halted  out  1  end of program reached.

Behaviour:
- Reset (async assert, released on clk edge):
  - out_valid=0, pc=0, data_frame=0, halted=0.
  - Internal fetch pointer fpc=0; state IDLE.
  - RAM contents are NOT reset and are preserved across rst.
- States: IDLE, WAIT (read in flight), VALID, HALT.
- Read issue: a read of fpc is issued in a cycle when state is IDLE (or VALID with accept), en=1, ld_we=0 and jmp=0. Data is registered; the state becomes VALID next cycle with out_valid=1 and pc=issued address.
- Latency: 1 cycle from issue to out_valid. Throughput: 1 frame/cycle while en=1 and out_ready=1.
- Accept = out_valid & out_ready. On accept:
  - fpc advances to pc+1.
  - If a read is issuable the same cycle, the next frame appears next cycle (back-to-back).
  - Otherwise go to IDLE with out_valid=0.
- VALID with out_ready=0: data_frame, pc and the field outputs are held stable. The frame is never dropped, even if en falls.
- jmp (any state incl. HALT, priority over accept):
  - Any presented frame is flushed; out_valid=0 next cycle.
  - fpc=jmp_addr; halted clears.
  - The read of jmp_addr issues the following cycle if en=1 and ld_we=0.
  - Minimum one bubble cycle.
- ld_we: writes ld_data to ld_addr on the clock edge, in any state. No read is issued in a ld_we cycle, so there is no read/write collision. A presented frame is unaffected even if its address is overwritten.
- en=0: no new reads. In-flight (WAIT) data still lands in VALID.
- End of program: accept of the frame at pc=DEPTH-1 without jmp → HALT, halted=1, out_valid=0. HALT is left only via jmp or rst.
- Field outputs are pure slices of data_frame. They equal 0 after reset.

Optional Feature:
- FETCH_WRAP_EN.
- Defined: accepting pc=DEPTH-1 wraps fpc to 0 and fetch continues. HALT is unreachable and halted is tied 0.
- Undefined: halt behaviour as above.

Decomposition:
- Shared package cpu_pkg holds:
  - field-slice localparams (op_code/reg_r/reg_w/data offsets as functions of W);
  - the fetch state enum (IDLE, WAIT, VALID, HALT);
  - frame width 4*W.
- One sub-module, prog_ram: DEPTH x 4W, single sync write port, single sync read port with read-enable, no reset.
- fetch_mem contains the FSM, the fpc counter and the output registers.

Test Plan (W=4, AW=4):
- Load then stream: load words 0x1234 at 0 and 0xA5F0 at 1 via ld_we. Raise en with out_ready=1 → out_valid rises 1 cycle later with pc=0, data_frame=0x1234, op_code=1, reg_r=2, reg_w=3, data=4; next cycle pc=1, data_frame=0xA5F0, op_code=A, data=0.
- Backpressure: out_ready=0 for 3 cycles while pc=2 is valid → pc and data_frame are stable for all 3 cycles. Raise out_ready → pc=3 next cycle; no address is skipped or duplicated.
- Jump flush: jmp=1, jmp_addr=9 while pc=4 is valid and out_ready=0 → out_valid=0 next cycle, then pc=9 valid with mem[9]. Frame 4 never accepted.
- End of program: stream to pc=15 and accept.
  - Without FETCH_WRAP_EN: halted=1, out_valid=0; remains halted for 10 cycles. jmp_addr=0 → halted=0, pc=0 valid.
  - With FETCH_WRAP_EN: pc=0 follows 15 with no gap.
- Load during fetch: assert ld_we for 2 cycles mid-stream → no new frame issued during those cycles. The held frame is unchanged. Writing the next address makes the new data appear when the stream resumes.
- Reset mid-operation: assert rst asynchronously (between edges) while pc=6 is valid → out_valid=0, pc=0, data_frame=0 immediately. After release, the first frame is mem[0], proving RAM contents are retained.
